// File: rtl/act_requant_packer_if.sv
// Activation stream in (from leaky_relu) and packed-word write bus out.
// The slave modport is the packer side; master is the producer/buffer side.
interface act_requant_packer_if #(
    parameter int ADDR_W = 12
);
    logic              in_valid;
    logic [31:0]       in_data;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [31:0]       wr_data;
    logic [3:0]        wr_strb;

    modport master (
        output in_valid, in_data,
        input  in_ready, wr_en, wr_addr, wr_data, wr_strb
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, wr_en, wr_addr, wr_data, wr_strb
    );
endinterface

// File: rtl/act_requant_packer.sv
// Requantizes signed 32-bit activations to int8 (scale, rounding shift, saturate)
// and packs four per little-endian word into the output buffer.
module act_requant_packer #(
    parameter int ADDR_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [CNT_W-1:0]   count,
    input  logic [15:0]        scale,
    input  logic [4:0]         shift,
    act_requant_packer_if.slave bus,
    output logic               busy,
    output logic               tile_done,
    output logic [CNT_W-1:0]   sat_count
);
    localparam int NUM_LANES = 4;
    localparam int STAGES    = 2;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]                state;
    logic [CNT_W-1:0]          cnt_q, acc_cnt;
    logic [15:0]               scale_q;
    logic [4:0]                shift_q;
    logic [ADDR_W-1:0]         waddr;
    logic [STAGES:0]           vld_pipe;
    logic                      accept, acc_last, word_done, wr_last;
    logic signed [47:0]        din_ext, scl_ext, mul, prod_q;
    logic signed [48:0]        half, rnd_in, shifted;
    logic [1:0]                s1_lane, s2_lane;
    logic                      s1_last, s2_last;
    logic [NUM_LANES-1:0][7:0] pack_q;
    logic [7:0]                sat_byte;
    logic                      clamped;

    assign bus.in_ready = (state == S_RUN) && (acc_cnt < cnt_q);
    assign accept       = bus.in_valid && bus.in_ready;
    assign acc_last     = (acc_cnt == cnt_q - CNT_W'(1));
    assign busy         = (state != S_IDLE);
    assign tile_done    = (state == S_DONE);
    // vld_pipe[0]: product reg, [1]: pack reg, [2]: write strobe (word-completing only)
    assign bus.wr_en    = vld_pipe[2];
    assign word_done    = vld_pipe[1] && ((s2_lane == 2'd3) || s2_last);

    always_comb begin
        din_ext  = {{16{bus.in_data[31]}}, bus.in_data};
        scl_ext  = {32'd0, scale_q};
        mul      = din_ext * scl_ext;
        half     = (shift_q == 5'd0) ? '0 : (49'sd1 <<< (shift_q - 5'd1));
        rnd_in   = {prod_q[47], prod_q} + half;
        shifted  = rnd_in >>> shift_q;
        sat_byte = shifted[7:0];
        clamped  = 1'b0;
        if (shifted > 49'sd127) begin
            sat_byte = 8'h7F;
            clamped  = 1'b1;
        end else if (shifted < -49'sd128) begin
            sat_byte = 8'h80;
            clamped  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cnt_q       <= '0;
            acc_cnt     <= '0;
            scale_q     <= '0;
            shift_q     <= '0;
            waddr       <= '0;
            vld_pipe    <= '0;
            prod_q      <= '0;
            s1_lane     <= '0;
            s1_last     <= 1'b0;
            s2_lane     <= '0;
            s2_last     <= 1'b0;
            wr_last     <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            bus.wr_strb <= '0;
            sat_count   <= '0;
        end else begin
            vld_pipe <= {word_done, vld_pipe[0], accept};

            case (state)
                S_IDLE: if (start) begin
                    cnt_q     <= count;
                    acc_cnt   <= '0;
                    scale_q   <= scale;
                    shift_q   <= shift;
                    waddr     <= base_addr;
                    sat_count <= '0;
                    state     <= (count == '0) ? S_DONE : S_RUN;
                end
                S_RUN:   if (accept && acc_last) state <= S_FLUSH;
                S_FLUSH: if (vld_pipe[2] && wr_last) state <= S_DONE;
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (accept) begin
                acc_cnt <= acc_cnt + CNT_W'(1);
                prod_q  <= mul;
                s1_lane <= acc_cnt[1:0];
                s1_last <= acc_last;
            end

            if (vld_pipe[0]) begin
                s2_lane <= s1_lane;
                s2_last <= s1_last;
                if (clamped && (sat_count != '1)) sat_count <= sat_count + CNT_W'(1);
            end

            // Partial final word: strobe covers lanes 0..s2_lane only
            if (word_done) begin
                bus.wr_addr <= waddr;
                waddr       <= waddr + ADDR_W'(1);
                bus.wr_data <= pack_q;
                bus.wr_strb <= 4'b1111 >> (2'd3 - s2_lane);
                wr_last     <= s2_last;
            end
        end
    end

    // Lane 0 of a new word clears the other lanes so unfilled bytes read as zero.
    for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                pack_q[k] <= '0;
            end else if (vld_pipe[0]) begin
                if (s1_lane == 2'(k))       pack_q[k] <= sat_byte;
                else if (s1_lane == 2'd0)   pack_q[k] <= '0;
            end
        end
    end
endmodule

// File: tb/tb_act_requant_packer.sv
// Directed + randomized bench for act_requant_packer with a write scoreboard.
module tb_act_requant_packer;
    localparam int ADDR_W = 12;
    localparam int CNT_W  = 16;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
        logic [3:0]        strb;
        int                cyc;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [CNT_W-1:0]  count;
    logic [15:0]       scale;
    logic [4:0]        shift;
    logic              busy, tile_done;
    logic [CNT_W-1:0]  sat_count;

    act_requant_packer_if #(.ADDR_W(ADDR_W)) bus ();

    act_requant_packer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .count(count), .scale(scale), .shift(shift), .bus(bus),
        .busy(busy), .tile_done(tile_done), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    int  last_acc = 0;
    int  last_wr_cyc = 0;
    wr_t sb[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: every write must match the oldest expectation, including its cycle.
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_wr", {63'd0, bus.wr_en}, 64'd0);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", 64'(bus.wr_addr), 64'(e.addr));
                chk("wr_data", 64'(bus.wr_data), 64'(e.data));
                chk("wr_strb", 64'(bus.wr_strb), 64'(e.strb));
                chk("wr_cycle", 64'(cyc), 64'(e.cyc));
                last_wr_cyc = cyc;
            end
        end
    end

    function automatic logic [8:0] model(input logic signed [31:0] d, input logic [15:0] sc,
                                         input logic [4:0] sh);
        longint p, r;
        p = longint'(d) * longint'(sc);
        r = (sh == 0) ? p : ((p + (64'sd1 <<< (sh - 1))) >>> sh);
        if (r > 127)       return {1'b1, 8'h7F};
        else if (r < -128) return {1'b1, 8'h80};
        else               return {1'b0, 8'(r)};
    endfunction

    task automatic expect_wr(input logic [ADDR_W-1:0] a, input logic [31:0] d, input logic [3:0] s);
        wr_t e;
        e.addr = a; e.data = d; e.strb = s; e.cyc = last_acc + 3;
        sb.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the element is accepted.
    task automatic send(input logic [31:0] v);
        int g = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        while (in_ready_now() == 1'b0 && g < 50) begin
            @(negedge clk);
            g++;
        end
        chk("accept_timeout", 64'(g < 50), 64'd1);
        last_acc = cyc;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    function automatic logic in_ready_now();
        return bus.in_ready;
    endfunction

    task automatic do_start(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] c,
                            input logic [15:0] sc, input logic [4:0] sh);
        base_addr = b; count = c; scale = sc; shift = sh; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        chk("start_sat_clr", 64'(sat_count), 64'd0);
        if (c == 0) begin
            chk("noop_done", 64'(tile_done), 64'd1);
            @(negedge clk);
            chk("noop_busy_end", 64'(busy), 64'd0);
            chk("noop_done_end", 64'(tile_done), 64'd0);
        end else begin
            chk("start_ready", 64'(bus.in_ready), 64'd1);
        end
    endtask

    task automatic wait_done(input int exp_sat);
        int g = 0;
        while (tile_done !== 1'b1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("done_timeout", 64'(g < 40), 64'd1);
        chk("done_latency", 64'(cyc), 64'(last_wr_cyc + 1));
        chk("sat_count", 64'(sat_count), 64'(exp_sat));
        chk("done_busy", 64'(busy), 64'd1);
        @(negedge clk);
        chk("busy_fall", 64'(busy), 64'd0);
        chk("done_fall", 64'(tile_done), 64'd0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
        chk("rst_wr_en", 64'(bus.wr_en), 64'd0);
        chk("rst_wr_addr", 64'(bus.wr_addr), 64'd0);
        chk("rst_wr_data", 64'(bus.wr_data), 64'd0);
        chk("rst_wr_strb", 64'(bus.wr_strb), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_tile_done", 64'(tile_done), 64'd0);
        chk("rst_sat_count", 64'(sat_count), 64'd0);
    endtask

    task automatic rand_tile(input logic [ADDR_W-1:0] b, input int n);
        logic [15:0]       sc;
        logic [4:0]        sh;
        logic [31:0]       word;
        logic [8:0]        m;
        logic [ADDR_W-1:0] a;
        logic signed [31:0] d;
        int                sats;
        sc = 16'($urandom_range(1, 65535));
        sh = 5'($urandom_range(8, 24));
        word = '0; a = b; sats = 0;
        do_start(b, CNT_W'(n), sc, sh);
        for (int i = 0; i < n; i++) begin
            d = $signed($urandom) >>> $urandom_range(0, 24);
            m = model(d, sc, sh);
            sats += int'(m[8]);
            word[8*(i%4) +: 8] = m[7:0];
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(d);
            if ((i % 4 == 3) || (i == n - 1)) begin
                expect_wr(a, word, 4'((1 << (i % 4 + 1)) - 1));
                a = a + ADDR_W'(1);
                word = '0;
            end
        end
        wait_done(sats);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; start = 1'b0; base_addr = '0; count = '0; scale = '0; shift = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        repeat (2) @(negedge clk);
        chk_reset_outputs();
        rst_n = 1'b1;
        @(negedge clk);

        // basic, plus extra in_valid after the count is reached
        do_start(12'h010, 4, 16'd1, 5'd0);
        send(-32'sd10); send(32'sd40); send(32'sd0); send(32'sd127);
        expect_wr(12'h010, 32'h7F0028F6, 4'hF);
        chk("ready_drop", 64'(bus.in_ready), 64'd0);
        bus.in_valid = 1'b1; bus.in_data = 32'd500;
        @(negedge clk);
        chk("extra_ready0", 64'(bus.in_ready), 64'd0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        wait_done(0);

        // rounding half up
        do_start(12'h020, 4, 16'd1, 5'd1);
        send(32'sd3); send(-32'sd3); send(32'sd5); send(-32'sd5);
        expect_wr(12'h020, 32'hFE03FF02, 4'hF);
        wait_done(0);

        // identity scale/shift, single partial word
        do_start(12'h030, 1, 16'd256, 5'd8);
        send(32'sd40);
        expect_wr(12'h030, 32'h00000028, 4'h1);
        wait_done(0);

        // saturation
        do_start(12'h040, 4, 16'd1, 5'd0);
        send(32'sd200); send(-32'sd200); send(32'sd1000000); send(-32'sd80);
        expect_wr(12'h040, 32'hB07F807F, 4'hF);
        wait_done(3);

        // partial final word with address wrap
        do_start(12'hFFF, 6, 16'd1, 5'd0);
        send(32'sd1); send(32'sd2); send(32'sd3); send(32'sd4);
        expect_wr(12'hFFF, 32'h04030201, 4'hF);
        send(32'sd5); send(32'sd6);
        expect_wr(12'h000, 32'h00000605, 4'h3);
        wait_done(0);

        // in_valid gaps and a start while busy
        do_start(12'h100, 4, 16'd1, 5'd0);
        send(-32'sd10);
        repeat (2) @(negedge clk);
        send(32'sd40);
        base_addr = 12'h300; count = 1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart_busy", 64'(busy), 64'd1);
        chk("restart_ready", 64'(bus.in_ready), 64'd1);
        send(32'sd0);
        repeat (3) @(negedge clk);
        send(32'sd127);
        expect_wr(12'h100, 32'h7F0028F6, 4'hF);
        wait_done(0);

        // reset mid-tile aborts
        do_start(12'h200, 4, 16'd1, 5'd0);
        send(32'sd1); send(32'sd2);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk_reset_outputs();
        repeat (6) @(negedge clk);
        chk("abort_idle", 64'(busy), 64'd0);

        do_start(12'h210, 4, 16'd1, 5'd0);
        send(32'sd5); send(32'sd6); send(32'sd7); send(32'sd8);
        expect_wr(12'h210, 32'h08070605, 4'hF);
        wait_done(0);

        // count = 0 no-op
        do_start(12'h220, 0, 16'd1, 5'd0);
        repeat (4) @(negedge clk);

        rand_tile(12'h400, 7);
        rand_tile(12'hFFE, 10);

        repeat (5) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
